// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: two-stage relative-branch resolver (Jcc, near Jcc, JMP, LOOPx, JCXZ) with mispredict flag and saturating stats
//   clk_i/rst_ni/flush_i : clock, sync active-low reset, pipeline flush
//   in_*                 : decoded branch op, valid/ready handshake
//   out_*                : resolved direction, redirect target, mispredict, count write-back, valid/ready handshake
//   stat_*               : saturating counts of good ops and mispredicts delivered
module branch_resolve_unit #(
  parameter int AWIDTH = 32,
  parameter int TAGW = 4,
  parameter int CNTW = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        in_op,
  input  logic              in_big,
  input  logic              in_asz,
  input  logic [31:0]       in_ecx,
  input  logic [4:0]        in_flags,
  input  logic [AWIDTH-1:0] in_next_ip,
  input  logic [31:0]       in_disp,
  input  logic              in_pred,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic [AWIDTH-1:0] out_target,
  output logic              out_mispred,
  output logic              out_bad,
  output logic              out_ecx_we,
  output logic [31:0]       out_ecx,
  output logic [TAGW-1:0]   out_tag,
  output logic [CNTW-1:0]   stat_resolved,
  output logic [CNTW-1:0]   stat_mispred
);
  logic              r_s1_v;
  logic [8:0]        r_s1_op;
  logic              r_s1_big;
  logic              r_s1_asz;
  logic              r_s1_pred;
  logic [31:0]       r_s1_ecx;
  logic [31:0]       r_s1_disp;
  logic [4:0]        r_s1_flags;
  logic [AWIDTH-1:0] r_s1_nip;
  logic [TAGW-1:0]   r_s1_tag;
  logic              r_s2_v;
  logic              r_s2_taken;
  logic              r_s2_mispred;
  logic              r_s2_bad;
  logic              r_s2_we;
  logic [AWIDTH-1:0] r_s2_target;
  logic [31:0]       r_s2_ecx;
  logic [TAGW-1:0]   r_s2_tag;
  logic [CNTW-1:0]   r_stat_res;
  logic [CNTW-1:0]   r_stat_mis;
  logic              w_s2_take;
  logic              w_acc;
  logic              w_xfer;
  logic              w_pf, w_vf, w_sf, w_cf, w_zf, w_lt;
  logic [2:0]        w_sel;
  logic              w_base;
  logic              w_cc;
  logic              w_jcc;
  logic              w_jmp;
  logic              w_loop;
  logic              w_jcxz;
  logic              w_bad;
  logic [31:0]       w_new_ecx;
  logic              w_new_nz;
  logic              w_cnt_z;
  logic              w_loop_ok;
  logic              w_taken;
  logic [AWIDTH-1:0] w_sum;
  logic [AWIDTH-1:0] w_tgt;
  assign w_s2_take = !r_s2_v || out_ready;
  assign in_ready  = rst_ni && !flush_i && (!r_s1_v || w_s2_take);
  assign w_acc     = in_valid && in_ready;
  assign w_xfer    = r_s2_v && out_ready;
  assign {w_pf, w_vf, w_sf, w_cf, w_zf} = r_s1_flags;
  assign w_lt = w_sf ^ w_vf;
  // Jcc condition pairs: bits [3:1] pick the base test, bit 0 inverts it
  assign w_sel  = r_s1_op[3:1];
  assign w_base = w_sel == 3'd0 ? w_vf :
                  w_sel == 3'd1 ? w_cf :
                  w_sel == 3'd2 ? w_zf :
                  w_sel == 3'd3 ? (w_cf | w_zf) :
                  w_sel == 3'd4 ? w_sf :
                  w_sel == 3'd5 ? w_pf :
                  w_sel == 3'd6 ? w_lt : (w_lt | w_zf);
  assign w_cc   = w_base ^ r_s1_op[0];
  assign w_jcc  = (!r_s1_op[8] && r_s1_op[7:4] == 4'h7) || (r_s1_op[8] && r_s1_op[7:4] == 4'h8);
  assign w_jmp  = !r_s1_op[8] && (r_s1_op[7:0] == 8'hEB || r_s1_op[7:0] == 8'hE9);
  assign w_loop = !r_s1_op[8] && r_s1_op[7:2] == 6'b111000 && r_s1_op[1:0] != 2'b11;
  assign w_jcxz = r_s1_op == 9'h0E3;
  assign w_bad  = !(w_jcc || w_jmp || w_loop || w_jcxz);
  // 16-bit address size decrements CX only; ECX[31:16] passes through
  assign w_new_ecx = r_s1_asz ? r_s1_ecx - 32'd1 : {r_s1_ecx[31:16], r_s1_ecx[15:0] - 16'd1};
  assign w_new_nz  = r_s1_asz ? |w_new_ecx : |w_new_ecx[15:0];
  assign w_cnt_z   = r_s1_asz ? ~|r_s1_ecx : ~|r_s1_ecx[15:0];
  // E2 LOOP needs only the count; E1 LOOPZ wants zf=1, E0 LOOPNZ wants zf=0
  assign w_loop_ok = r_s1_op[1] || (r_s1_op[0] == w_zf);
  assign w_taken   = w_jcc ? w_cc :
                     w_jmp ? 1'b1 :
                     w_loop ? (w_new_nz && w_loop_ok) :
                     (w_jcxz && w_cnt_z);
  assign w_sum = r_s1_nip + r_s1_disp[AWIDTH-1:0];
  assign w_tgt = r_s1_big ? w_sum : AWIDTH'(w_sum[15:0]);
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) r_s1_v <= 1'b0;
    else if (in_ready) r_s1_v <= in_valid;
    else if (w_s2_take) r_s1_v <= 1'b0;
  end
  always_ff @(posedge clk_i) begin
    if (w_acc) begin
      r_s1_op    <= in_op;
      r_s1_big   <= in_big;
      r_s1_asz   <= in_asz;
      r_s1_pred  <= in_pred;
      r_s1_ecx   <= in_ecx;
      r_s1_disp  <= in_disp;
      r_s1_flags <= in_flags;
      r_s1_nip   <= in_next_ip;
      r_s1_tag   <= in_tag;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s2_v       <= 1'b0;
      r_s2_taken   <= 1'b0;
      r_s2_mispred <= 1'b0;
      r_s2_bad     <= 1'b0;
      r_s2_we      <= 1'b0;
      r_s2_target  <= '0;
      r_s2_ecx     <= '0;
      r_s2_tag     <= '0;
    end else begin
      if (flush_i) r_s2_v <= 1'b0;
      else if (w_s2_take) r_s2_v <= r_s1_v;
      if (w_s2_take && r_s1_v) begin
        r_s2_taken   <= w_taken;
        r_s2_mispred <= w_taken ^ r_s1_pred;
        r_s2_bad     <= w_bad;
        r_s2_we      <= w_loop;
        r_s2_target  <= w_taken ? w_tgt : r_s1_nip;
        r_s2_ecx     <= w_loop ? w_new_ecx : r_s1_ecx;
        r_s2_tag     <= r_s1_tag;
      end
    end
  end
  // a transfer in a flush cycle still counts: it completed on that edge
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stat_res <= '0;
      r_stat_mis <= '0;
    end else if (w_xfer && !r_s2_bad) begin
      if (~&r_stat_res) r_stat_res <= r_stat_res + 1'b1;
      if (r_s2_mispred && ~&r_stat_mis) r_stat_mis <= r_stat_mis + 1'b1;
    end
  end
  assign out_valid     = r_s2_v;
  assign out_taken     = r_s2_taken;
  assign out_target    = r_s2_target;
  assign out_mispred   = r_s2_mispred;
  assign out_bad       = r_s2_bad;
  assign out_ecx_we    = r_s2_we;
  assign out_ecx       = r_s2_ecx;
  assign out_tag       = r_s2_tag;
  assign stat_resolved = r_stat_res;
  assign stat_mispred  = r_stat_mis;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: randomized and directed checks of branch_resolve_unit against a behavioural model
module tb_branch_resolve_unit;
  localparam int AW = 32;
  localparam int TW = 4;
  localparam int CW = 16;
  logic clk = 0;
  logic rst_ni = 0;
  logic flush_i = 0;
  logic in_valid = 0;
  logic out_ready = 0;
  logic in_ready;
  logic [8:0] in_op = 0;
  logic in_big = 0;
  logic in_asz = 0;
  logic in_pred = 0;
  logic [31:0] in_ecx = 0;
  logic [31:0] in_disp = 0;
  logic [4:0] in_flags = 0;
  logic [AW-1:0] in_next_ip = 0;
  logic [TW-1:0] in_tag = 0;
  logic out_valid, out_taken, out_mispred, out_bad, out_ecx_we;
  logic [AW-1:0] out_target;
  logic [31:0] out_ecx;
  logic [TW-1:0] out_tag;
  logic [CW-1:0] stat_resolved, stat_mispred;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic taken, bad, mispred, we;
    logic [31:0] ecx;
    logic [AW-1:0] target;
    logic [TW-1:0] tag;
  } exp_t;
  branch_resolve_unit #(.AWIDTH(AW), .TAGW(TW), .CNTW(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_big(in_big), .in_asz(in_asz),
    .in_ecx(in_ecx), .in_flags(in_flags), .in_next_ip(in_next_ip), .in_disp(in_disp),
    .in_pred(in_pred), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken), .out_target(out_target),
    .out_mispred(out_mispred), .out_bad(out_bad), .out_ecx_we(out_ecx_we), .out_ecx(out_ecx),
    .out_tag(out_tag), .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [8:0] op, input logic big, input logic asz,
                                 input logic [31:0] ecx, input logic [4:0] fl, input logic [31:0] nip,
                                 input logic [31:0] disp, input logic pred, input logic [TW-1:0] tag);
    exp_t e;
    int o;
    logic pf, vf, sf, cf, zf, lt;
    longint unsigned m, cnt, nc, sum;
    o = int'(op);
    {pf, vf, sf, cf, zf} = fl;
    lt = sf != vf;
    e.taken = 0; e.bad = 0; e.we = 0; e.ecx = ecx; e.tag = tag;
    m = asz ? (64'd1 << 32) : 64'd65536;
    cnt = 64'(ecx) % m;
    if ((o >> 4) == 'h7 || (o >> 4) == 'h18) begin
      case (o % 16)
        0: e.taken = vf;          1: e.taken = !vf;
        2: e.taken = cf;          3: e.taken = !cf;
        4: e.taken = zf;          5: e.taken = !zf;
        6: e.taken = cf || zf;    7: e.taken = !cf && !zf;
        8: e.taken = sf;          9: e.taken = !sf;
        10: e.taken = pf;         11: e.taken = !pf;
        12: e.taken = lt;         13: e.taken = !lt;
        14: e.taken = lt || zf;   default: e.taken = !(lt || zf);
      endcase
    end else if (o == 'hEB || o == 'hE9) e.taken = 1;
    else if (o >= 'hE0 && o <= 'hE2) begin
      nc = (cnt + m - 1) % m;
      e.ecx = asz ? 32'(nc) : {ecx[31:16], 16'(nc)};
      e.we = 1;
      e.taken = nc != 0 && (o == 'hE2 || (o == 'hE1 && zf) || (o == 'hE0 && !zf));
    end else if (o == 'hE3) e.taken = cnt == 0;
    else e.bad = 1;
    sum = (64'(nip) + 64'(disp)) % (big ? (64'd1 << AW) : 64'd65536);
    e.target = e.taken ? AW'(sum) : nip;
    e.mispred = e.taken != pred;
    return e;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    rst_ni = 0; in_valid = 0; flush_i = 0; out_ready = 0;
    tick(2);
    rst_ni = 1;
  endtask
  task automatic set_op(input logic [8:0] op, input logic big, input logic asz, input logic [31:0] ecx,
                        input logic [4:0] fl, input logic [31:0] nip, input logic [31:0] disp,
                        input logic pred, input logic [TW-1:0] tag);
    in_op = op; in_big = big; in_asz = asz; in_ecx = ecx; in_flags = fl;
    in_next_ip = nip; in_disp = disp; in_pred = pred; in_tag = tag;
  endtask
  task automatic rand_fields(input logic [TW-1:0] tag);
    logic [8:0] bads [6];
    bads = '{9'h090, 9'h08F, 9'h17F, 9'h1EB, 9'h0E4, 9'h0C3};
    case ($urandom_range(0, 5))
      0: in_op = {5'h07, 4'($urandom)};
      1: in_op = {5'h18, 4'($urandom)};
      2: in_op = 9'h0E0 + 9'($urandom_range(0, 3));
      3: in_op = $urandom_range(0, 1) ? 9'h0EB : 9'h0E9;
      4: in_op = bads[$urandom_range(0, 5)];
      default: in_op = 9'($urandom);
    endcase
    case ($urandom_range(0, 2))
      0: in_ecx = $urandom;
      1: in_ecx = {16'($urandom), 16'($urandom_range(0, 2))};
      default: in_ecx = 32'($urandom_range(0, 2));
    endcase
    in_big = 1'($urandom); in_asz = 1'($urandom); in_pred = 1'($urandom);
    in_flags = 5'($urandom); in_next_ip = $urandom; in_disp = $urandom; in_tag = tag;
  endtask
  // presents one op with out_ready high and returns once out_valid rises (lat = edges since accept)
  task automatic issue(output int lat);
    lat = -1;
    out_ready = 1; in_valid = 1;
    #1;
    for (int k = 0; k < 10 && !in_ready; k++) tick(1);
    @(posedge clk);
    #2;
    in_valid = 0;
    for (int c = 1; c <= 6; c++) begin
      if (out_valid) begin lat = c; break; end
      tick(1);
    end
  endtask
  task automatic test_reset();
    rst_ni = 0; in_valid = 1; out_ready = 1;
    tick(1);
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_chk++;
    if ({out_valid, out_taken, out_mispred, out_bad, out_ecx_we, out_target, out_ecx, out_tag, stat_resolved, stat_mispred} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b t=%b m=%b b=%b we=%b tgt=%h ecx=%h tag=%h sr=%h sm=%h want all 0",
               out_valid, out_taken, out_mispred, out_bad, out_ecx_we, out_target, out_ecx, out_tag, stat_resolved, stat_mispred);
    end
    in_valid = 0;
    rst_ni = 1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    tick(1);
  endtask
  task automatic test_jcc();
    int lat;
    do_reset();
    set_op(9'h074, 1, 0, 0, 5'b00001, 32'h1000, 32'hFFFF_FFF0, 0, 4'h3);
    issue(lat);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL je_latency: got %0d want 2", lat); end
    n_chk++;
    if ({out_taken, out_target, out_mispred, out_bad, out_tag} !== {1'b1, 32'h0FF0, 1'b1, 1'b0, 4'h3}) begin
      n_fail++;
      $display("FAIL je_result: got t=%b tgt=%h m=%b b=%b tag=%h want t=1 tgt=00000ff0 m=1 b=0 tag=3",
               out_taken, out_target, out_mispred, out_bad, out_tag);
    end
    tick(1);
    n_chk++;
    if ({stat_resolved, stat_mispred} !== {16'd1, 16'd1}) begin
      n_fail++; $display("FAIL je_stats: got res=%0d mis=%0d want 1 1", stat_resolved, stat_mispred);
    end
  endtask
  task automatic test_loop();
    int lat;
    do_reset();
    set_op(9'h0E2, 1, 0, 32'hABCD_0001, 0, 32'h20, 32'hFFFF_FFFC, 0, 4'h1);
    issue(lat);
    n_chk++;
    if ({lat == 2, out_taken, out_target, out_ecx, out_ecx_we} !== {1'b1, 1'b0, 32'h20, 32'hABCD_0000, 1'b1}) begin
      n_fail++;
      $display("FAIL loop_zero: got lat=%0d t=%b tgt=%h ecx=%h we=%b want lat=2 t=0 tgt=00000020 ecx=abcd0000 we=1",
               lat, out_taken, out_target, out_ecx, out_ecx_we);
    end
    tick(1);
    set_op(9'h0E2, 1, 0, 32'h0001_0000, 0, 32'h20, 32'hFFFF_FFFC, 0, 4'h2);
    issue(lat);
    n_chk++;
    if ({out_taken, out_target, out_ecx, out_ecx_we} !== {1'b1, 32'h1C, 32'h0001_FFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL loop_wrap: got t=%b tgt=%h ecx=%h we=%b want t=1 tgt=0000001c ecx=0001ffff we=1",
               out_taken, out_target, out_ecx, out_ecx_we);
    end
    tick(1);
    set_op(9'h0E3, 1, 0, 32'h1234_0000, 0, 32'h100, 32'h10, 1, 4'h4);
    issue(lat);
    n_chk++;
    if ({out_taken, out_target, out_ecx_we, out_mispred} !== {1'b1, 32'h110, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL jcxz_cx0: got t=%b tgt=%h we=%b m=%b want t=1 tgt=00000110 we=0 m=0", out_taken, out_target, out_ecx_we, out_mispred);
    end
    tick(1);
    set_op(9'h0E3, 1, 1, 32'h1234_0000, 0, 32'h100, 32'h10, 1, 4'h5);
    issue(lat);
    n_chk++;
    if ({out_taken, out_target, out_ecx_we, out_mispred} !== {1'b0, 32'h100, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL jecxz_nz: got t=%b tgt=%h we=%b m=%b want t=0 tgt=00000100 we=0 m=1", out_taken, out_target, out_ecx_we, out_mispred);
    end
    tick(1);
  endtask
  task automatic test_near_wrap();
    int lat;
    do_reset();
    set_op(9'h18F, 0, 0, 0, 5'b01100, 32'hFFF0, 32'h20, 1, 4'h6);
    issue(lat);
    n_chk++;
    if ({out_taken, out_target, out_mispred} !== {1'b1, 32'h0010, 1'b0}) begin
      n_fail++; $display("FAIL jg_wrap: got t=%b tgt=%h m=%b want t=1 tgt=00000010 m=0", out_taken, out_target, out_mispred);
    end
    tick(1);
    set_op(9'h18F, 0, 0, 0, 5'b01101, 32'hFFF0, 32'h20, 1, 4'h7);
    issue(lat);
    n_chk++;
    if ({out_taken, out_target, out_mispred} !== {1'b0, 32'hFFF0, 1'b1}) begin
      n_fail++; $display("FAIL jg_zf: got t=%b tgt=%h m=%b want t=0 tgt=0000fff0 m=1", out_taken, out_target, out_mispred);
    end
    tick(1);
  endtask
  task automatic test_bad();
    int lat;
    do_reset();
    set_op(9'h090, 1, 1, 32'h5, 5'h1F, 32'h4000, 32'h100, 1, 4'h8);
    issue(lat);
    n_chk++;
    if ({out_bad, out_taken, out_target, out_mispred, out_ecx_we} !== {1'b1, 1'b0, 32'h4000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL bad_90: got b=%b t=%b tgt=%h m=%b we=%b want b=1 t=0 tgt=00004000 m=1 we=0",
               out_bad, out_taken, out_target, out_mispred, out_ecx_we);
    end
    tick(1);
    set_op(9'h17F, 1, 1, 32'h5, 5'h1F, 32'h4000, 32'h100, 0, 4'h9);
    issue(lat);
    n_chk++;
    if ({out_bad, out_taken, out_mispred} !== {1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL bad_0f7f: got b=%b t=%b m=%b want b=1 t=0 m=0", out_bad, out_taken, out_mispred);
    end
    tick(1);
    n_chk++;
    if ({stat_resolved, stat_mispred} !== 32'h0) begin
      n_fail++; $display("FAIL bad_stats: got res=%0d mis=%0d want 0 0", stat_resolved, stat_mispred);
    end
  endtask
  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int er = 0, em = 0, nout = 0, nin = 0;
    do_reset();
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(posedge clk);
      #2;
      out_ready = cyc >= 880 || $urandom_range(0, 3) != 0;
      in_valid = cyc < 870 && $urandom_range(0, 3) != 0;
      rand_fields(4'(nin));
      #1;
      if (out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: got unexpected output tag=%h want none", out_tag);
        end else begin
          e = q.pop_front();
          nout++;
          if ({out_taken, out_bad, out_mispred, out_ecx_we, out_target, out_tag, e.we ? out_ecx : 32'h0} !==
              {e.taken, e.bad, e.mispred, e.we, e.target, e.tag, e.we ? e.ecx : 32'h0}) begin
            n_fail++;
            $display("FAIL rand_result: got t=%b b=%b m=%b we=%b tgt=%h tag=%h ecx=%h want t=%b b=%b m=%b we=%b tgt=%h tag=%h ecx=%h",
                     out_taken, out_bad, out_mispred, out_ecx_we, out_target, out_tag, out_ecx,
                     e.taken, e.bad, e.mispred, e.we, e.target, e.tag, e.ecx);
          end
          if (!e.bad) begin
            er = er == 65535 ? er : er + 1;
            if (e.mispred) em = em == 65535 ? em : em + 1;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_op, in_big, in_asz, in_ecx, in_flags, in_next_ip, in_disp, in_pred, in_tag));
        nin++;
      end
    end
    tick(1);
    n_chk++;
    if (q.size() != 0 || nout != nin || nin < 200) begin
      n_fail++; $display("FAIL rand_drain: got in=%0d out=%0d left=%0d want all delivered", nin, nout, q.size());
    end
    n_chk++;
    if (stat_resolved !== CW'(er) || stat_mispred !== CW'(em)) begin
      n_fail++; $display("FAIL rand_stats: got res=%0d mis=%0d want %0d %0d", stat_resolved, stat_mispred, er, em);
    end
  endtask
  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int sent = 0, stalls = 3, held_n = 0;
    logic blocked = 0;
    logic [TW-1:0] got[$];
    logic [TW-1:0] h_tag;
    logic [AW-1:0] h_tgt;
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk);
      #2;
      out_ready = !(out_valid && stalls > 0);
      if (out_valid && stalls > 0) stalls--;
      in_valid = sent < 3;
      rand_fields(4'(sent + 1));
      #1;
      if (in_valid && !in_ready) blocked = 1;
      if (out_valid && !out_ready) begin
        if (held_n > 0) begin
          n_chk++;
          if (out_tag !== h_tag || out_target !== h_tgt) begin
            n_fail++; $display("FAIL b2b_hold: got tag=%h tgt=%h want tag=%h tgt=%h", out_tag, out_target, h_tag, h_tgt);
          end
        end
        h_tag = out_tag; h_tgt = out_target; held_n++;
      end
      if (out_valid && out_ready) begin
        got.push_back(out_tag);
        if (q.size() > 0) begin
          e = q.pop_front();
          n_chk++;
          if ({out_taken, out_bad, out_mispred, out_target, out_tag} !== {e.taken, e.bad, e.mispred, e.target, e.tag}) begin
            n_fail++;
            $display("FAIL b2b_result: got t=%b b=%b m=%b tgt=%h tag=%h want t=%b b=%b m=%b tgt=%h tag=%h",
                     out_taken, out_bad, out_mispred, out_target, out_tag, e.taken, e.bad, e.mispred, e.target, e.tag);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_op, in_big, in_asz, in_ecx, in_flags, in_next_ip, in_disp, in_pred, in_tag));
        sent++;
      end
    end
    n_chk++;
    if (got.size() != 3 || got[0] !== 4'h1 || got[1] !== 4'h2 || got[2] !== 4'h3) begin
      n_fail++; $display("FAIL b2b_order: got %0d tags %p want 1 2 3", got.size(), got);
    end
    n_chk++;
    if (!blocked || held_n != 3) begin
      n_fail++; $display("FAIL b2b_backpressure: got blocked=%b held=%0d want blocked=1 held=3", blocked, held_n);
    end
  endtask
  task automatic test_flush();
    do_reset();
    out_ready = 0;
    set_op(9'h0EB, 1, 1, 0, 0, 32'h100, 32'h8, 0, 4'hA);
    in_valid = 1;
    tick(1);
    in_tag = 4'hB;
    tick(1);
    in_valid = 0;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_fill: got out_valid=%b want 1", out_valid); end
    flush_i = 1; in_valid = 1; in_tag = 4'hC;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick(1);
    flush_i = 0; in_valid = 0;
    n_chk++;
    if (out_valid !== 1'b0 || stat_resolved !== 0 || stat_mispred !== 0) begin
      n_fail++; $display("FAIL flush_drop: got v=%b res=%0d mis=%0d want 0 0 0", out_valid, stat_resolved, stat_mispred);
    end
    tick(1);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got out_valid=%b want 0", out_valid); end
    in_valid = 1; in_tag = 4'hD;
    tick(1);
    in_valid = 0;
    tick(1);
    out_ready = 1; flush_i = 1;
    tick(1);
    flush_i = 0;
    n_chk++;
    if (out_valid !== 1'b0 || stat_resolved !== 1 || stat_mispred !== 1) begin
      n_fail++; $display("FAIL flush_xfer: got v=%b res=%0d mis=%0d want 0 1 1", out_valid, stat_resolved, stat_mispred);
    end
  endtask
  task automatic test_saturate();
    int acc = 0;
    int lat;
    do_reset();
    set_op(9'h0EB, 1, 1, 0, 0, 32'h200, 32'h10, 0, 4'h1);
    out_ready = 1; in_valid = 1;
    for (int cyc = 0; cyc < 70000 && acc < 65535; cyc++) begin
      #1;
      if (in_ready) acc++;
      tick(1);
    end
    in_valid = 0;
    tick(4);
    n_chk++;
    if (acc != 65535 || stat_mispred !== 16'hFFFF || stat_resolved !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_reach: got acc=%0d res=%h mis=%h want 65535 ffff ffff", acc, stat_resolved, stat_mispred);
    end
    issue(lat);
    tick(2);
    n_chk++;
    if (lat != 2 || stat_mispred !== 16'hFFFF || stat_resolved !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold: got lat=%0d res=%h mis=%h want 2 ffff ffff", lat, stat_resolved, stat_mispred);
    end
    in_valid = 1;
    tick(3);
    rst_ni = 0;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_in_ready: got %b want 0", in_ready); end
    tick(1);
    n_chk++;
    if ({out_valid, out_taken, out_mispred, out_bad, out_ecx_we, out_target, out_ecx, out_tag, stat_resolved, stat_mispred} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%b t=%b tgt=%h tag=%h sr=%h sm=%h want all 0",
               out_valid, out_taken, out_target, out_tag, stat_resolved, stat_mispred);
    end
    rst_ni = 1; in_valid = 0;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_release: got %b want 1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick(1);
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_empty: got out_valid=%b want 0", out_valid); end
    end
  endtask
  initial begin
    test_reset();
    test_jcc();
    test_loop();
    test_near_wrap();
    test_bad();
    test_random();
    test_back_to_back();
    test_flush();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
